// File: rtl/chip8_pkg.sv
// Shared CHIP-8 types and RAM geometry used by the RAM arbiter and its read tracker.
package chip8_pkg;

  localparam int unsigned RAM_ADDR_W = 12;
  localparam int unsigned RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_BLIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    M_CPU    = 2'd0,
    M_BLIT   = 2'd1,
    M_LOADER = 2'd2
  } master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_rd_track.sv
// Two-stage {valid, master} shift that turns accepted read beats into rvalid strobes.
// Stage one lines up with ram_en and tells the top when to capture ram_out.
module ram_rd_track
  import chip8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue,
  input  master_id_t issue_id,
  output logic       rd_pending,
  output logic       cpu_rvalid,
  output logic       blit_rvalid
);

  rd_tag_t tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag         <= '0;
      cpu_rvalid  <= 1'b0;
      blit_rvalid <= 1'b0;
    end else begin
      tag         <= '{valid: issue, id: issue_id};
      cpu_rvalid  <= tag.valid && (tag.id == M_CPU);
      blit_rvalid <= tag.valid && (tag.id == M_BLIT);
    end
  end

  assign rd_pending = tag.valid;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port program/sprite RAM between the CPU and the blitter: round-robin,
// burst lock with a starvation cap. Define RAM_ARB_LOADER_EN to add a write-only priority loader.
module ram_arbiter
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W    = RAM_ADDR_W,
  parameter int unsigned DATA_W    = RAM_DATA_W,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_lock,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              blit_req,
  input  logic              blit_lock,
  input  logic              blit_wr,
  input  logic [ADDR_W-1:0] blit_addr,
  input  logic [DATA_W-1:0] blit_wdata,
  output logic              blit_gnt,
  output logic              blit_rvalid,
`ifdef RAM_ARB_LOADER_EN
  input  logic              loader_req,
  input  logic              loader_wr,
  input  logic [ADDR_W-1:0] loader_addr,
  input  logic [DATA_W-1:0] loader_wdata,
  output logic              loader_gnt,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int unsigned CNT_W = 8;

  arb_state_t        state, state_next;
  master_id_t        rr, rr_next;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_next;
  logic              loader_act;
  logic              ld_gnt;
  logic              cap_hit;
  logic              beat_v;
  logic              beat_wr;
  master_id_t        beat_id;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_wdata;
  logic              rd_pending;

`ifdef RAM_ARB_LOADER_EN
  assign loader_act = loader_req;
  assign loader_gnt = ld_gnt;
`else
  assign loader_act = 1'b0;
`endif

  // State register: FSM state, round-robin pointer, burst counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= M_CPU;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      rr        <= rr_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // Grant decode; the loader overrides everyone at any beat boundary.
  always_comb begin
    cpu_gnt  = 1'b0;
    blit_gnt = 1'b0;
    ld_gnt   = loader_act;
    cap_hit  = 1'b0;
    if (!loader_act) begin
      unique case (state)
        IDLE: begin
          if (cpu_req && (!blit_req || rr == M_CPU)) cpu_gnt = 1'b1;
          else if (blit_req)                          blit_gnt = 1'b1;
        end
        OWN_CPU: begin
          if (cpu_req) begin
            if (blit_req && burst_cnt >= CNT_W'(MAX_BURST)) cap_hit = 1'b1;
            else                                           cpu_gnt = 1'b1;
          end
        end
        OWN_BLIT: begin
          if (blit_req) begin
            if (cpu_req && burst_cnt >= CNT_W'(MAX_BURST)) cap_hit = 1'b1;
            else                                          blit_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state; a capped owner hands the pointer to the waiting master.
  always_comb begin
    state_next     = state;
    rr_next        = rr;
    burst_cnt_next = burst_cnt;
    if (cap_hit) begin
      state_next     = IDLE;
      burst_cnt_next = '0;
      rr_next        = (state == OWN_CPU) ? M_BLIT : M_CPU;
    end else if (cpu_gnt || blit_gnt) begin
      if (state == IDLE && cpu_req && blit_req) rr_next = cpu_gnt ? M_BLIT : M_CPU;
      if (cpu_gnt ? cpu_lock : blit_lock) begin
        state_next = cpu_gnt ? OWN_CPU : OWN_BLIT;
        if (cpu_gnt ? blit_req : cpu_req) burst_cnt_next = burst_cnt + CNT_W'(1);
      end else begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end
    end else if (state != IDLE && !loader_act) begin
      state_next     = IDLE;
      burst_cnt_next = '0;
    end
  end

  // Accepted-beat mux.
  always_comb begin
    beat_id    = M_CPU;
    beat_wr    = cpu_wr;
    beat_addr  = cpu_addr;
    beat_wdata = cpu_wdata;
    if (blit_gnt) begin
      beat_id    = M_BLIT;
      beat_wr    = blit_wr;
      beat_addr  = blit_addr;
      beat_wdata = blit_wdata;
    end
`ifdef RAM_ARB_LOADER_EN
    if (ld_gnt) begin
      beat_id    = M_LOADER;
      beat_wr    = loader_wr;
      beat_addr  = loader_addr;
      beat_wdata = loader_wdata;
    end
`endif
  end

  assign beat_v = cpu_gnt | blit_gnt | ld_gnt;

  // RAM command and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      ram_in   <= '0;
      rdata    <= '0;
    end else begin
      ram_en <= beat_v;
      ram_wr <= beat_v & beat_wr;
      if (beat_v) begin
        ram_addr <= beat_addr;
        ram_in   <= beat_wdata;
      end
      if (rd_pending) rdata <= ram_out;
    end
  end

  ram_rd_track u_rd_track (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (beat_v && !beat_wr && (beat_id != M_LOADER)),
    .issue_id    (beat_id),
    .rd_pending  (rd_pending),
    .cpu_rvalid  (cpu_rvalid),
    .blit_rvalid (blit_rvalid)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected RAM beats and read returns,
// a negedge monitor pops and compares them whenever the DUT presents ram_en or rvalid.
module tb_ram_arbiter;
  import chip8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_lock, cpu_wr;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        blit_req, blit_lock, blit_wr;
  logic [11:0] blit_addr;
  logic [7:0]  blit_wdata;
  logic        blit_gnt, blit_rvalid;
`ifdef RAM_ARB_LOADER_EN
  logic        loader_req, loader_wr, loader_gnt;
  logic [11:0] loader_addr;
  logic [7:0]  loader_wdata;
`endif
  logic [7:0]  rdata;
  logic        ram_en, ram_wr;
  logic [11:0] ram_addr;
  logic [7:0]  ram_in, ram_out;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .blit_req(blit_req), .blit_lock(blit_lock), .blit_wr(blit_wr), .blit_addr(blit_addr),
    .blit_wdata(blit_wdata), .blit_gnt(blit_gnt), .blit_rvalid(blit_rvalid),
`ifdef RAM_ARB_LOADER_EN
    .loader_req(loader_req), .loader_wr(loader_wr), .loader_addr(loader_addr),
    .loader_wdata(loader_wdata), .loader_gnt(loader_gnt),
`endif
    .rdata(rdata), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic wr; logic [11:0] addr; logic [7:0] data; } beat_t;
  typedef struct { int cyc; master_id_t id; logic [7:0] data; } rd_t;
  beat_t ramq[$];
  rd_t   rdq[$];
  beat_t exp_b;
  rd_t   exp_r;

  function automatic logic [7:0] exp_mem(input logic [11:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Behavioural RAM: combinational read of the presented address, write on the clock.
  logic [7:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = exp_mem(12'(i));
    mem[12'h200] = 8'h12;
  end
  always @(posedge clk) if (ram_en && ram_wr) mem[ram_addr] <= ram_in;
  assign ram_out = mem[ram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
  endtask

  // Monitor: every ram_en / rvalid must match the head of its queue, on the expected cycle.
  always @(negedge clk) begin
    if (ram_en) begin
      if (ramq.size() == 0) fail_evt("ram_beat", "unexpected ram_en");
      else begin
        exp_b = ramq.pop_front();
        chk("ram_cycle", 32'(cyc), 32'(exp_b.cyc));
        chk("ram_wr", 32'(ram_wr), 32'(exp_b.wr));
        chk("ram_addr", 32'(ram_addr), 32'(exp_b.addr));
        chk("ram_in", 32'(ram_in), 32'(exp_b.data));
      end
    end else if (ramq.size() != 0 && ramq[0].cyc <= cyc) begin
      fail_evt("ram_beat", "ram_en missing");
      exp_b = ramq.pop_front();
    end
    if (cpu_rvalid || blit_rvalid) begin
      chk("rvalid_onehot", 32'(cpu_rvalid && blit_rvalid), 32'd0);
      if (rdq.size() == 0) fail_evt("rvalid", "unexpected rvalid");
      else begin
        exp_r = rdq.pop_front();
        chk("rd_cycle", 32'(cyc), 32'(exp_r.cyc));
        chk("rd_owner", cpu_rvalid ? 32'(M_CPU) : 32'(M_BLIT), 32'(exp_r.id));
        chk("rdata", 32'(rdata), 32'(exp_r.data));
      end
    end else if (rdq.size() != 0 && rdq[0].cyc <= cyc) begin
      fail_evt("rvalid", "rvalid missing");
      exp_r = rdq.pop_front();
    end
  end

  // One cycle: check grants at negedge, queue the expected results, move past the edge.
  task automatic step(input logic ec, input logic eb, input logic [7:0] ed);
    @(negedge clk);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    chk("blit_gnt", 32'(blit_gnt), 32'(eb));
    if (ec) begin
      ramq.push_back('{cyc + 1, cpu_wr, cpu_addr, cpu_wdata});
      if (!cpu_wr) rdq.push_back('{cyc + 2, M_CPU, ed});
    end
    if (eb) begin
      ramq.push_back('{cyc + 1, blit_wr, blit_addr, blit_wdata});
      if (!blit_wr) rdq.push_back('{cyc + 2, M_BLIT, ed});
    end
    @(posedge clk); #1;
  endtask

  task automatic check_quiet();
    chk("q_ram_en", 32'(ram_en), 32'd0);
    chk("q_ram_wr", 32'(ram_wr), 32'd0);
    chk("q_ram_addr", 32'(ram_addr), 32'd0);
    chk("q_ram_in", 32'(ram_in), 32'd0);
    chk("q_rdata", 32'(rdata), 32'd0);
    chk("q_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("q_blit_rvalid", 32'(blit_rvalid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_lock = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    blit_req = 1'b0; blit_lock = 1'b0; blit_wr = 1'b0; blit_addr = '0; blit_wdata = '0;
`ifdef RAM_ARB_LOADER_EN
    loader_req = 1'b0; loader_wr = 1'b0; loader_addr = '0; loader_wdata = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet();
    @(posedge clk); #1;

    // CPU-only read of 0x200 holding 0x12
    cpu_req = 1'b1; cpu_addr = 12'h200;
    step(1'b1, 1'b0, 8'h12);
    cpu_req = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Both request without lock: strict alternation starting with CPU
    cpu_req = 1'b1; blit_req = 1'b1; cpu_addr = 12'h010; blit_addr = 12'h020;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, 1'b0, exp_mem(cpu_addr));
        cpu_addr = cpu_addr + 12'd1;
      end else begin
        step(1'b0, 1'b1, exp_mem(blit_addr));
        blit_addr = blit_addr + 12'd1;
      end
    end
    cpu_req = 1'b0; blit_req = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Locked 20-beat blitter read against a waiting CPU: capped after 16 beats
    cpu_req = 1'b1; cpu_addr = 12'h030;
    blit_req = 1'b1; blit_lock = 1'b1; blit_addr = 12'h400;
    step(1'b1, 1'b0, exp_mem(12'h030));
    cpu_addr = 12'h031;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, exp_mem(blit_addr));
      blit_addr = blit_addr + 12'd1;
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, exp_mem(12'h031));
    cpu_req = 1'b0;
    for (int k = 16; k < 20; k++) begin
      blit_lock = (k != 19);
      step(1'b0, 1'b1, exp_mem(blit_addr));
      blit_addr = blit_addr + 12'd1;
    end
    blit_req = 1'b0; blit_lock = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // CPU write 0x05 to 0x300, then read it back
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h05;
    step(1'b1, 1'b0, 8'h00);
    cpu_wr = 1'b0; cpu_wdata = 8'h00;
    step(1'b1, 1'b0, 8'h05);
    cpu_req = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Reset the cycle after a read grant: the read is dropped
    cpu_req = 1'b1; cpu_addr = 12'h200;
    step(1'b1, 1'b0, 8'h12);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    rdq.delete(rdq.size() - 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet();
    @(posedge clk); #1;

    // After reset the pointer favours the CPU again
    cpu_req = 1'b1; blit_req = 1'b1; cpu_addr = 12'h050; blit_addr = 12'h060;
    step(1'b1, 1'b0, exp_mem(12'h050));
    cpu_req = 1'b0;
    step(1'b0, 1'b1, exp_mem(12'h060));
    blit_req = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);

`ifdef RAM_ARB_LOADER_EN
    // Loader preempts a requesting CPU until it drops
    cpu_req = 1'b1; cpu_addr = 12'h701;
    loader_req = 1'b1; loader_wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      loader_addr = 12'h700 + 12'(k);
      loader_wdata = 8'hA0 + 8'(k);
      @(negedge clk);
      chk("loader_gnt", 32'(loader_gnt), 32'd1);
      chk("cpu_gnt_ld", 32'(cpu_gnt), 32'd0);
      chk("blit_gnt_ld", 32'(blit_gnt), 32'd0);
      ramq.push_back('{cyc + 1, 1'b1, loader_addr, loader_wdata});
      @(posedge clk); #1;
    end
    loader_req = 1'b0;
    step(1'b1, 1'b0, 8'hA1);
    cpu_req = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);
`endif

    step(1'b0, 1'b0, 8'h00);
    chk("ramq_drained", 32'(ramq.size()), 32'd0);
    chk("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
